signed_divider: RTL and testbench

- Sequential signed two's-complement divider, the inverse datapath of the team's sign-magnitude multiplier.
- Operands are converted to magnitudes and run through restoring division, one quotient bit per clock. Signs are then applied: quotient sign = XOR of operand signs; remainder sign = dividend sign.
- Sits beside the multiplier in the MDR arithmetic unit and shares its start/ready control style.

---
 rtl/signed_divider_pkg.sv | 17 +
 rtl/signed_divider_if.sv | 30 +++
 rtl/signed_divider_sign_magnitude_converter.sv | 20 ++
 rtl/signed_divider.sv | 177 +++++++++++++++++
 tb/tb_signed_divider.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/signed_divider_pkg.sv
// Shared arithmetic-unit package for the MDR block.
// Provides the default operand width, the divider state encoding and the
// most-negative operand constant derived from the default width.
package mdr_pkg;

  localparam int unsigned WORD_LENGTH = 16;

  localparam logic [WORD_LENGTH-1:0] MOST_NEGATIVE = {1'b1, {(WORD_LENGTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/signed_divider_if.sv
// Start/ready handshake and operand/result bus of the signed divider.
//   start, dividend, divisor           : requester -> divider
//   quotient, remainder, ready, busy,
//   div_by_zero, overflow              : divider -> requester
// master: requester side; slave: divider side.
interface signed_divider_if #(
  parameter int unsigned WORD_LENGTH = mdr_pkg::WORD_LENGTH
);

  logic                   start;
  logic [WORD_LENGTH-1:0] dividend;
  logic [WORD_LENGTH-1:0] divisor;
  logic [WORD_LENGTH-1:0] quotient;
  logic [WORD_LENGTH-1:0] remainder;
  logic                   ready;
  logic                   busy;
  logic                   div_by_zero;
  logic                   overflow;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, ready, busy, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, ready, busy, div_by_zero, overflow
  );

endinterface

// File: rtl/signed_divider_sign_magnitude_converter.sv
// Combinational two's-complement conditional negate.
//   value_i : input value
//   neg_i   : negate when 1
//   value_o : neg_i ? -value_i : value_i, truncated to WIDTH
// With neg_i tied to value_i's MSB it yields the unsigned magnitude
// (the most-negative value maps to 2^(WIDTH-1), still representable
// as unsigned); with neg_i a latched sign it applies that sign.
module sign_magnitude_converter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] value_o
);

  always_comb begin
    value_o = neg_i ? ('0 - value_i) : value_i;
  end

endmodule

// File: rtl/signed_divider.sv
// Sequential signed divider: restoring division on operand magnitudes,
// one quotient bit per clock, signs applied afterwards.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : start/operand inputs and quotient/remainder/ready/busy/
//           div_by_zero/overflow outputs (signed_divider_if.slave)
module signed_divider
  import mdr_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = mdr_pkg::WORD_LENGTH
) (
  input logic             clk,
  input logic             reset,
  signed_divider_if.slave bus
);

  localparam int unsigned W     = WORD_LENGTH;
  localparam int unsigned CNT_W = $clog2(W + 1);
  localparam logic [W-1:0] MOST_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MINUS_ONE = '1;

  state_t state_q, state_d;

  logic [W-1:0]     mag_dvd_q, mag_dvd_d;   // dividend magnitude, shifts into quotient
  logic [W-1:0]     mag_dvs_q, mag_dvs_d;
  logic [W-1:0]     prem_q, prem_d;         // partial remainder
  logic [W-1:0]     dividend_q, dividend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             zero_q, zero_d;
  logic             ovf_case_q, ovf_case_d;
  logic [W-1:0]     quotient_q, quotient_d;
  logic [W-1:0]     remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [W-1:0] abs_dvd, abs_dvs, q_signed, r_signed;
  logic [W-1:0] shifted_rem;
  logic [W:0]   trial;

  sign_magnitude_converter #(.WIDTH(W)) u_abs_dividend (
    .value_i(bus.dividend), .neg_i(bus.dividend[W-1]), .value_o(abs_dvd)
  );
  sign_magnitude_converter #(.WIDTH(W)) u_abs_divisor (
    .value_i(bus.divisor), .neg_i(bus.divisor[W-1]), .value_o(abs_dvs)
  );
  sign_magnitude_converter #(.WIDTH(W)) u_sign_quotient (
    .value_i(mag_dvd_q), .neg_i(q_neg_q), .value_o(q_signed)
  );
  sign_magnitude_converter #(.WIDTH(W)) u_sign_remainder (
    .value_i(prem_q), .neg_i(r_neg_q), .value_o(r_signed)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. Divide-by-zero also passes through SIGN, which is
  // where all results are written; this puts its ready in cycle 2.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.divisor == '0) ? SIGN : RUN;
      RUN:     if (cnt_q == CNT_W'(1)) state_d = SIGN;
      SIGN:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.ready = (state_q == DONE);
    bus.busy  = (state_q == RUN) || (state_q == SIGN);
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

  // Datapath. The partial remainder stays below |divisor| <= 2^(W-1), so
  // its MSB is always 0 and the shifted value fits in W bits.
  always_comb begin
    mag_dvd_d   = mag_dvd_q;
    mag_dvs_d   = mag_dvs_q;
    prem_d      = prem_q;
    dividend_d  = dividend_q;
    cnt_d       = cnt_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    zero_d      = zero_q;
    ovf_case_d  = ovf_case_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    shifted_rem = {prem_q[W-2:0], mag_dvd_q[W-1]};
    trial       = {1'b0, shifted_rem} - {1'b0, mag_dvs_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mag_dvd_d  = abs_dvd;
          mag_dvs_d  = abs_dvs;
          prem_d     = '0;
          dividend_d = bus.dividend;
          cnt_d      = CNT_W'(W);
          q_neg_d    = bus.dividend[W-1] ^ bus.divisor[W-1];
          r_neg_d    = bus.dividend[W-1];
          zero_d     = (bus.divisor == '0);
          ovf_case_d = (bus.dividend == MOST_NEG) && (bus.divisor == MINUS_ONE);
          dbz_d      = 1'b0;
          ovf_d      = 1'b0;
        end
      end
      RUN: begin
        prem_d    = trial[W] ? shifted_rem : trial[W-1:0];
        mag_dvd_d = {mag_dvd_q[W-2:0], ~trial[W]};
        cnt_d     = cnt_q - CNT_W'(1);
      end
      SIGN: begin
        if (zero_q) begin
          quotient_d  = '0;
          remainder_d = dividend_q;
          dbz_d       = 1'b1;
          ovf_d       = 1'b0;
        end else if (ovf_case_q) begin
          quotient_d  = MOST_NEG;
          remainder_d = '0;
          ovf_d       = 1'b1;
        end else begin
          quotient_d  = q_signed;
          remainder_d = r_signed;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mag_dvd_q   <= '0;
      mag_dvs_q   <= '0;
      prem_q      <= '0;
      dividend_q  <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_case_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      mag_dvd_q   <= mag_dvd_d;
      mag_dvs_q   <= mag_dvs_d;
      prem_q      <= prem_d;
      dividend_q  <= dividend_d;
      cnt_q       <= cnt_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      zero_q      <= zero_d;
      ovf_case_q  <= ovf_case_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider (WORD_LENGTH = 16).
// An arithmetic reference model predicts results, ready timing and busy;
// directed operations additionally carry hand-computed literal results.
module tb_signed_divider;

  localparam int W = 16;

  logic clk;
  logic reset;

  int checks = 0;
  int passes = 0;

  signed_divider_if #(.WORD_LENGTH(W)) bus ();

  signed_divider #(.WORD_LENGTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: truncating signed division with the flag rules applied.
  function automatic void model(input int a, input int b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output logic ov);
    int qi;
    int ri;
    if (b == 0) begin
      q  = '0;
      r  = a[W-1:0];
      dz = 1'b1;
      ov = 1'b0;
    end else begin
      qi = a / b;
      ri = a % b;
      q  = qi[W-1:0];
      r  = ri[W-1:0];
      dz = 1'b0;
      ov = (qi > (2 ** (W - 1)) - 1);
    end
  endfunction

  // Compare process: checks ready/busy every cycle and results on ready.
  int          m_cyc = 0;
  bit          m_pending = 0;
  int          m_acc = 0;
  int          m_due = 0;
  logic [W-1:0] m_q, m_r;
  logic        m_dz, m_ov;

  initial begin
    int a;
    int b;
    forever begin
      @(negedge clk);
      m_cyc++;
      if (!reset) begin
        m_pending = 0;
        check("reset_outputs",
              {bus.quotient, bus.remainder, bus.ready, bus.busy, bus.div_by_zero, bus.overflow},
              64'd0);
      end else begin
        check("model_ready", bus.ready, m_pending && (m_cyc == m_due));
        check("model_busy", bus.busy, m_pending && (m_cyc >= m_acc) && (m_cyc < m_due));
        if (m_pending && m_cyc == m_due) begin
          check("model_quotient", bus.quotient, m_q);
          check("model_remainder", bus.remainder, m_r);
          check("model_div_by_zero", bus.div_by_zero, m_dz);
          check("model_overflow", bus.overflow, m_ov);
        end
        if (bus.start && (!m_pending || m_cyc > m_due)) begin
          a = $signed(bus.dividend);
          b = $signed(bus.divisor);
          model(a, b, m_q, m_r, m_dz, m_ov);
          m_pending = 1;
          m_acc     = m_cyc + 1;
          m_due     = m_acc + ((b == 0) ? 2 : W + 2) - 1;
        end
      end
    end
  end

  task automatic run_op(input string name, input int a, input int b,
                        input int exp_q, input int exp_r, input bit exp_dz,
                        input bit exp_ov, input int exp_lat, input bit inject);
    int k;
    bit seen;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    eq = exp_q[W-1:0];
    er = exp_r[W-1:0];
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = a[W-1:0];
    bus.divisor  = b[W-1:0];
    @(posedge clk); #1;
    bus.start = 1'b0;
    k    = 0;
    seen = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (bus.ready) seen = 1;
      else if (inject && k == 5) begin
        #2;
        bus.start    = 1'b1;
        bus.dividend = 16'd50;
        bus.divisor  = 16'd5;
      end else if (inject && k == 10) begin
        #2;
        bus.start = 1'b0;
      end
    end
    if (!seen) check({name, "_ready_timeout"}, 0, 1);
    check({name, "_latency"}, k, exp_lat);
    check({name, "_quotient"}, bus.quotient, eq);
    check({name, "_remainder"}, bus.remainder, er);
    check({name, "_div_by_zero"}, bus.div_by_zero, exp_dz);
    check({name, "_overflow"}, bus.overflow, exp_ov);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int first;
    int second;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #3 reset = 1'b0;
    #1;
    check("reset_quotient", bus.quotient, 0);
    check("reset_ready_busy", {bus.ready, bus.busy}, 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;

    run_op("basic_100_7",      100,    7,     14,  2, 0, 0, 18, 0);
    run_op("neg_100_7",       -100,    7,    -14, -2, 0, 0, 18, 0);
    run_op("100_neg7",         100,   -7,    -14,  2, 0, 0, 18, 0);
    run_op("neg100_neg7",     -100,   -7,     14, -2, 0, 0, 18, 0);
    run_op("mostneg_neg1",  -32768,   -1, -32768,  0, 0, 1, 18, 0);
    run_op("mostneg_1",     -32768,    1, -32768,  0, 0, 0, 18, 0);
    run_op("small_7_100",        7,  100,      0,  7, 0, 0, 18, 0);
    run_op("max_div_neg_3",  32767,   -3, -10922,  1, 0, 0, 18, 0);
    run_op("div_zero_5",         5,    0,      0,  5, 1, 0,  2, 0);
    run_op("after_dbz_9_3",      9,    3,      3,  0, 0, 0, 18, 0);
    run_op("ignored_start",    100,    7,     14,  2, 0, 0, 18, 1);

    // start held high: back-to-back operations
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = 16'd100;
    bus.divisor  = 16'd7;
    @(posedge clk); #1;
    k = 0; first = 0; second = 0;
    while (second == 0 && k < 60) begin
      @(negedge clk);
      k++;
      if (bus.ready) begin
        if (first == 0) first = k;
        else begin
          second = k;
          #2 bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    check("held_first_ready", first, 18);
    check("held_ready_spacing", second - first, 19);

    // reset in RUN cycle 8
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = 16'd100;
    bus.divisor  = 16'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("midrun_busy", bus.busy, 1);
    #2 reset = 1'b0;
    #1;
    check("midrun_reset_quotient", bus.quotient, 0);
    check("midrun_reset_remainder", bus.remainder, 0);
    check("midrun_reset_ctrl", {bus.ready, bus.busy, bus.div_by_zero, bus.overflow}, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    repeat (25) @(negedge clk);
    run_op("post_reset_100_7", 100, 7, 14, 2, 0, 0, 18, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
